// File: rtl/apmu_ibex_rf_wport_ctrl_if.sv
// Write-port bundle between the core/APMU requesters and the register file.
// Carries the core writeback request, the APMU write request and its response,
// the arbitrated register file write, and the clear-done flag.
//   master : requester / register-file side (drives *_i, observes *_o)
//   slave  : the write-port controller      (observes *_i, drives *_o)
interface apmu_ibex_rf_wport_ctrl_if #(
  parameter int unsigned DataWidth = 32
);
  localparam int unsigned RegAddrWidth = 5;

  // Core writeback
  logic                    core_we_i;
  logic [RegAddrWidth-1:0] core_waddr_i;
  logic [DataWidth-1:0]    core_wdata_i;
  logic                    core_stall_o;

  // APMU write requester
  logic                    ext_valid_i;
  logic [RegAddrWidth-1:0] ext_waddr_i;
  logic [DataWidth-1:0]    ext_wdata_i;
  logic                    ext_ready_o;
  logic                    ext_err_o;

  // Register file write port
  logic                    rf_we_o;
  logic [RegAddrWidth-1:0] rf_waddr_o;
  logic [DataWidth-1:0]    rf_wdata_o;

  // Clear sequence status
  logic                    init_done_o;

  modport master (
    output core_we_i, core_waddr_i, core_wdata_i,
    output ext_valid_i, ext_waddr_i, ext_wdata_i,
    input  core_stall_o, ext_ready_o, ext_err_o,
    input  rf_we_o, rf_waddr_o, rf_wdata_o, init_done_o
  );

  modport slave (
    input  core_we_i, core_waddr_i, core_wdata_i,
    input  ext_valid_i, ext_waddr_i, ext_wdata_i,
    output core_stall_o, ext_ready_o, ext_err_o,
    output rf_we_o, rf_waddr_o, rf_wdata_o, init_done_o
  );
endinterface

// File: rtl/apmu_ibex_rf_wport_ctrl.sv
// Write-port controller in front of the FPGA register file's single write port.
// After reset it zeroes x1..x(N-1) (the FPGA RF has no reset of its own), then
// shares the port between core writeback (priority) and an APMU write requester.
// A waiting APMU write is forced through after StarveLimit denied cycles by
// stalling the core for one cycle.
// Ports:
//   clk_i   : clock
//   rst_ni  : synchronous active-low reset
//   bus     : slave side of apmu_ibex_rf_wport_ctrl_if
//             core_we/waddr/wdata_i, core_stall_o   core writeback
//             ext_valid/waddr/wdata_i, ext_ready_o   APMU write handshake
//             ext_err_o                              registered out-of-range pulse
//             rf_we/waddr/wdata_o                    register file write port
//             init_done_o                            registered clear-complete flag
module apmu_ibex_rf_wport_ctrl #(
  parameter bit          RV32E        = 1'b0,
  parameter int unsigned DataWidth    = 32,
  parameter bit          ClearOnReset = 1'b1,
  parameter int unsigned StarveLimit  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  apmu_ibex_rf_wport_ctrl_if.slave bus
);

  localparam int unsigned RegAddrWidth = 5;
  localparam int unsigned AddrWidth    = RV32E ? 4 : 5;
  localparam int unsigned NumRegs      = 1 << AddrWidth;
  localparam int unsigned StarveWidth  = 4;

  localparam logic [AddrWidth-1:0]   LastReg   = AddrWidth'(NumRegs - 1);
  localparam logic [StarveWidth-1:0] StarveMax = StarveWidth'(StarveLimit);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [AddrWidth-1:0]    clr_cnt_q, clr_cnt_d;
  logic [StarveWidth-1:0]  starve_cnt_q, starve_cnt_d;
  logic                    ext_err_q, ext_err_d;
  logic                    init_done_q, init_done_d;

  logic                    force_ext;
  logic                    ext_hs;
  logic                    ext_addr_ok;
  logic                    rf_we;
  logic [RegAddrWidth-1:0] rf_waddr;
  logic [DataWidth-1:0]    rf_wdata;
  logic                    ext_ready;
  logic                    core_stall;

  // RV32E only decodes 16 registers; an APMU address with bit 4 set is out of range.
  assign ext_addr_ok = !(RV32E && bus.ext_waddr_i[4]);

  // State and counter registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ClearOnReset ? S_CLEAR : S_RUN;
      clr_cnt_q    <= AddrWidth'(1);
      starve_cnt_q <= '0;
      ext_err_q    <= 1'b0;
      init_done_q  <= !ClearOnReset;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      ext_err_q    <= ext_err_d;
      init_done_q  <= init_done_d;
    end
  end

  // Next-state, arbitration and write-port mux
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    starve_cnt_d = starve_cnt_q;
    ext_err_d    = 1'b0;
    init_done_d  = init_done_q;
    force_ext    = 1'b0;
    ext_hs       = 1'b0;
    rf_we        = 1'b0;
    rf_waddr     = '0;
    rf_wdata     = '0;
    ext_ready    = 1'b0;
    core_stall   = 1'b1;

    case (state_q)
      S_CLEAR: begin
        // Zero one register per cycle; both requesters are held off.
        rf_we        = 1'b1;
        rf_waddr     = RegAddrWidth'(clr_cnt_q);
        rf_wdata     = '0;
        core_stall   = 1'b1;
        ext_ready    = 1'b0;
        clr_cnt_d    = clr_cnt_q + AddrWidth'(1);
        starve_cnt_d = '0;
        if (clr_cnt_q == LastReg) begin
          state_d     = S_RUN;
          init_done_d = 1'b1;
        end
      end

      S_RUN: begin
        // Core wins unless the APMU has been denied StarveLimit times in a row.
        force_ext  = bus.ext_valid_i && (starve_cnt_q == StarveMax);
        ext_ready  = !bus.core_we_i || force_ext;
        core_stall = bus.core_we_i && force_ext;
        ext_hs     = bus.ext_valid_i && ext_ready;

        if (ext_hs) begin
          // Writes to x0 or out-of-range addresses are acknowledged but dropped.
          rf_we     = ext_addr_ok && (bus.ext_waddr_i != '0);
          rf_waddr  = bus.ext_waddr_i;
          rf_wdata  = bus.ext_wdata_i;
          ext_err_d = !ext_addr_ok;
        end else begin
          rf_we    = bus.core_we_i;
          rf_waddr = bus.core_waddr_i;
          rf_wdata = bus.core_wdata_i;
        end

        // Count consecutive denied cycles, saturating at the limit.
        if (ext_hs || !bus.ext_valid_i) begin
          starve_cnt_d = '0;
        end else if (starve_cnt_q != StarveMax) begin
          starve_cnt_d = starve_cnt_q + StarveWidth'(1);
        end
      end
    endcase

    // Reset gates the port immediately, ahead of the reset edge.
    if (!rst_ni) begin
      rf_we      = 1'b0;
      ext_ready  = 1'b0;
      core_stall = 1'b1;
    end
  end

  assign bus.rf_we_o      = rf_we;
  assign bus.rf_waddr_o   = rf_waddr;
  assign bus.rf_wdata_o   = rf_wdata;
  assign bus.ext_ready_o  = ext_ready;
  assign bus.core_stall_o = core_stall;
  assign bus.ext_err_o    = ext_err_q;
  assign bus.init_done_o  = init_done_q;

endmodule

// File: doc/apmu_ibex_rf_wport_ctrl.md
# apmu_ibex_rf_wport_ctrl

Write-port controller placed directly in front of the FPGA register file's single write port. It clears registers x1..x(N-1) after reset, because the FPGA register file has no reset of its own. It then shares the write port between core writeback and an APMU-side write requester. Core writeback has priority, with a bounded-starvation override that stalls the core for one cycle to let a waiting APMU write through.

## Interface
- RV32E, 0: 1 gives 16 registers (4-bit address), 0 gives 32.
- DataWidth, 32: data width.
- ClearOnReset, 1: 1 runs the zeroing sequence after reset; 0 enters RUN directly.
- StarveLimit, 4: number of consecutive denied cycles before the APMU request is forced through; range 1..15.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; synchronous, active-low.
- core_we_i  in  1  core writeback enable.
- core_waddr_i  in  5  core writeback address.
- core_wdata_i  in  DataWidth  core writeback data.
- core_stall_o  out  1  core write this cycle not performed; core must hold and re-present it.
- ext_valid_i  in  1  APMU write request.
- ext_waddr_i  in  5  APMU write address.
- ext_wdata_i  in  DataWidth  APMU write data.
- ext_ready_o  out  1  APMU write accepted this cycle when ext_valid_i=1.
- ext_err_o  out  1  registered one-cycle pulse: accepted APMU write had an out-of-range address.
- rf_we_o  out  1  register file write enable.
- rf_waddr_o  out  5  register file write address.
- rf_wdata_o  out  DataWidth  register file write data.
- init_done_o  out  1  registered; 1 once the clear sequence is complete.

## Operation
- Derived values: N = 16 (RV32E) or 32. The clear counter is ADDR_WIDTH bits wide.
- State machine has two states, CLEAR and RUN.
- Reset (rst_ni=0 at a clock edge):
  - state <= CLEAR if ClearOnReset, else RUN.
  - clr_cnt <= 1, starve_cnt <= 0, ext_err_o <= 0.
  - init_done_o <= !ClearOnReset.
- Whenever rst_ni=0, outputs are gated regardless of state: rf_we_o=0, ext_ready_o=0, core_stall_o=1.
- CLEAR state:
  - Drive rf_we_o=1, rf_waddr_o=clr_cnt, rf_wdata_o=0.
  - Drive core_stall_o=1, ext_ready_o=0.
  - clr_cnt increments each cycle.
  - In the cycle where clr_cnt=N-1: next state is RUN and init_done_o <= 1.
  - starve_cnt holds at 0 during CLEAR.
- RUN state:
  - force = ext_valid_i && (starve_cnt == StarveLimit).
  - ext_ready_o = !core_we_i || force.
  - core_stall_o = core_we_i && force.
  - If ext_valid_i && ext_ready_o, the port carries the APMU write. rf_we_o is 1 only if the address is in range and non-zero.
  - Otherwise the port carries the core write (rf_we_o=core_we_i) with the core address and data.
- Address rules:
  - An APMU write to x0 is accepted and dropped, with no error.
  - In RV32E, an APMU address with bit 4 set is accepted and dropped, and ext_err_o=1 the next cycle.
  - A core write to x0 passes through unchanged; the register file ignores it.
- starve_cnt update, applied only in RUN:
  - APMU handshake, or ext_valid_i=0: starve_cnt <= 0.
  - ext_valid_i=1 && !ext_ready_o: starve_cnt <= min(starve_cnt+1, StarveLimit).
- The APMU requester must hold valid, address and data stable until ready is returned. The controller does not check this.

## Timing
- Both paths are combinational, with zero latency from request to rf_* outputs.
- Core write: issued in the same cycle it is presented, unless stalled.
- APMU write: issued in the handshake cycle.
- Clear length is N-1 cycles: 31 for RV32I, 15 for RV32E. init_done_o rises on the first RUN cycle.
- Worst-case APMU wait under continuous core writes is StarveLimit cycles. The forced write lands on cycle StarveLimit+1.
- Worst-case core stall is 1 cycle per StarveLimit+1 cycles.
- Reset asserted mid-CLEAR or mid-RUN takes effect at the next edge and restarts the clear from x1. Any unaccepted APMU request is simply not acknowledged.
- ext_err_o is registered with 1-cycle latency. All other outputs are combinational from state and inputs.

## Test plan
- Clear sequence, RV32I, ClearOnReset=1: release rst_ni → rf_we_o=1 with addresses 1..31 and data 0 on 31 consecutive cycles; core_stall_o=1 throughout; init_done_o=1 on cycle 32. Preload the model memory with 0xDEADBEEF; read back 0 from every register.
- Core/APMU conflict, StarveLimit=4: core_we_i=1 every cycle, APMU holds a write of 0x1234 to x5 → ext_ready_o=0 for 4 cycles; cycle 5 has ext_ready_o=1, core_stall_o=1, rf_waddr_o=5, rf_wdata_o=0x1234; the stalled core write issues on cycle 6.
- Idle core: ext_valid_i=1 to x7 with core_we_i=0 → handshake in the same cycle; starve_cnt stays 0; back-to-back APMU writes are accepted every cycle.
- Address edge cases, RV32E=1: APMU write to x0 → accepted, rf_we_o=0, no error; APMU write to x20 → accepted, rf_we_o=0, ext_err_o=1 the next cycle; clear sequence is 15 cycles.
- Reset mid-clear: assert rst_ni=0 at clr_cnt=10 for one edge → rf_we_o=0 while reset is low; clear restarts at x1 and completes 31 cycles after release.
- ClearOnReset=0: init_done_o=1 and RUN immediately after reset; a core write to x3 issues on the first cycle.
